event_encoder: RTL
==================

Name: event_encoder

Overview:
- Inverse companion of the team's 2-to-4 decoder: collects one-hot or multi-hot request pulses on N lines and emits the binary index of each pending request, one at a time.
- Highest index has priority.
- Indices are delivered over a valid/ready handshake to a downstream consumer.
- Index bit ordering matches the decoder: s_out[W-1] is s0 (MSB) and s_out[0] is s1 (LSB), so decoding s_out recreates the original line.
- Sits between event sources (buttons, interrupt lines) and a sequential consumer.

Parameters:
- N, 4, number of request lines.
- W, 2, index width; must equal ceil(log2(N)), N ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- y_in  input  N  request pulses, sampled every rising edge; any number of bits may be set.
- s_out  output  W  index of the granted request; valid only while valid=1.
- valid  output  1  s_out holds an undelivered index.
- ready  input  1  consumer accepts s_out this edge when valid=1.
- pending  output  N  current pending-request register, for observation.
- ovf  output  1  sticky flag: a request arrived on a line that was already pending.
- clr_ovf  input  1  synchronous clear of ovf.

Behaviour:
- Reset: one clock, reset asynchronous and active-low.
  - rst_n=0 immediately forces pending=0, s_out=0, valid=0, ovf=0 and state=IDLE.
  - A reset asserted mid-handshake drops valid in the same cycle and discards all pending requests.
- Pending register, updated every edge:
  - pending_next = (pending & ~gmask) | y_in.
  - gmask is the one-hot of s_out when valid&&ready, otherwise 0.
  - If a new request arrives on the line being granted in that same edge, the line stays pending and is counted as a new request, not an overflow.
- Overflow:
  - ovf sets on any edge where y_in[i]=1 and pending[i]=1 and line i is not being granted that edge.
  - Set wins over a simultaneous clr_ovf.
  - Otherwise clr_ovf=1 clears ovf.
- Priority encoder:
  - prio(v) returns the highest set index of v.
  - It also returns an any-bit flag, which is 0 when v=0.
- State machine, two states:
  - IDLE: valid=0. If pending≠0, load s_out=prio(pending), set valid=1 and go to HOLD. Otherwise stay in IDLE.
  - HOLD: valid=1 and s_out is held stable until accepted, even if a higher-priority request arrives.
    - On valid&&ready, if pending_next≠0, load s_out=prio(pending_next) and stay in HOLD, giving back-to-back delivery at one index per cycle.
    - On valid&&ready with pending_next=0, clear valid and go to IDLE.
    - With ready=0, stay in HOLD with no change.
- The bit for the held index stays set in pending until its handshake.
- Latency:
  - A request sampled at edge k appears in pending after edge k.
  - With the block idle, valid rises after edge k+1. Minimum latency is 2 cycles.
- Throughput: one index per clock while ready=1 and requests remain.
- ready while valid=0 is ignored.

Decomposition:
- Shared package event_enc_pkg holds:
  - constants N_DEF=4 and W_DEF=2;
  - state encoding IDLE=1'b0, HOLD=1'b1;
  - the onehot(idx) helper function.
- One sub-module, prio_enc4: a purely combinational, N-parameterised highest-index encoder with outputs idx[W-1:0] and any. Instantiate it twice, once on pending and once on pending_next.
- All state lives in event_encoder.

Test Plan:
1. Reset then idle: rst_n=0→1, y_in=0 for 5 cycles → valid=0, s_out=0, pending=0, ovf=0 throughout.
2. Single request, ready=1: pulse y_in=4'b0100 for 1 cycle → valid=1 with s_out=2'b10 two edges later; pending=0 and valid=0 one cycle after acceptance.
3. Multi-hot with priority and back-to-back: pulse y_in=4'b1011, ready=1 → s_out sequence 11, 01, 00 on consecutive cycles, then valid=0.
4. Hold stability: ready=0, pulse 4'b0001, then pulse 4'b1000 while valid=1 → s_out stays 00 until ready=1, then 11 on the next cycle.
5. Overflow and clear: pulse 4'b0010 twice with ready=0 → ovf=1 after the second pulse. clr_ovf=1 in the same edge as a third 0010 pulse → ovf stays 1. clr_ovf alone → ovf=0.
6. Reset mid-operation: pending=4'b1110 with valid=1, assert rst_n=0 between edges → valid, pending and s_out are 0 immediately. After release, no stale index is delivered.

Source files
------------

// File: rtl/event_enc_pkg.sv
// Shared constants, FSM encoding and the one-hot helper for the event encoder.
package event_enc_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 2;
    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Result is MAX_N wide; callers size-cast it down to their own line count.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational highest-index priority encoder with an any-bit flag.
module prio_enc4 #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] v,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan, so the last (highest) set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |v;

endmodule

// File: rtl/event_encoder.sv
// Collects request pulses and delivers their binary indices, highest first,
// over a valid/ready handshake; sticky ovf flags re-requests of pending lines.
module event_encoder
    import event_enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] y_in,
    output logic [W-1:0] s_out,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         ovf,
    input  logic         clr_ovf
);

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_s_out;
    logic [W-1:0]   w_s_next;
    logic [N-1:0]   r_pending;
    logic           r_ovf;

    logic           w_accept;
    logic [N-1:0]   w_gmask;
    logic [N-1:0]   w_pend_next;
    logic           w_ovf_hit;
    logic [W-1:0]   w_idx_cur;
    logic           w_any_cur;
    logic [W-1:0]   w_idx_next;
    logic           w_any_next;

    assign w_accept    = (r_state == HOLD) && ready;
    assign w_gmask     = w_accept ? N'(onehot(32'(r_s_out))) : '0;
    assign w_pend_next = (r_pending & ~w_gmask) | y_in;
    // A line being granted this edge may be re-requested without overflow.
    assign w_ovf_hit   = |(y_in & r_pending & ~w_gmask);

    prio_enc4 #(.N(N), .W(W)) u_prio_cur (
        .v   (r_pending),
        .idx (w_idx_cur),
        .any (w_any_cur)
    );

    prio_enc4 #(.N(N), .W(W)) u_prio_next (
        .v   (w_pend_next),
        .idx (w_idx_next),
        .any (w_any_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s_out;
        unique case (r_state)
            IDLE: begin
                if (w_any_cur) begin
                    w_s_next     = w_idx_cur;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // s_out is frozen until accepted, even if a higher line arrives.
                if (w_accept) begin
                    if (w_any_next) begin
                        w_s_next = w_idx_next;
                    end else begin
                        w_s_next     = '0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_s_next     = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_s_out   <= '0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_s_out   <= w_s_next;
            r_pending <= w_pend_next;
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign s_out   = r_s_out;
    assign valid   = (r_state == HOLD);
    assign pending = r_pending;
    assign ovf     = r_ovf;

endmodule
